// File: rtl/dsm2_stim_echip65_if.sv
// rtl/dsm2_stim_echip65_if.sv - sample handshake bundle feeding the delta-sigma stimulus modulator
//
// Ports (signals):
//   sample_in     signed input sample, DATA_WIDTH bits (producer -> modulator)
//   sample_valid  sample_in carries a sample (producer -> modulator)
//   sample_ready  modulator takes sample_in this cycle (modulator -> producer)
// Modports: master = sample producer, slave = modulator.
interface dsm2_stim_echip65_if #(
    parameter int DATA_WIDTH = 12
);
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         sample_valid;
    logic                         sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/dsm2_stim_echip65.sv
// rtl/dsm2_stim_echip65.sv - second-order digital delta-sigma modulator producing a 1-bit stimulus stream
//
// Ports:
//   clk            modulator clock, one output bit per enabled cycle
//   reset          synchronous, active-high; dominates enable and the handshake
//   enable         advance the modulator; when low every register holds
//   smp            sample handshake (slave): sample_in / sample_valid / sample_ready
//   bitstream_out  registered modulator bit (drives the filter-row input)
//   frame_start    one-cycle pulse on the first bit computed from a newly loaded slot
//   overflow       sticky: an integrator clamped
//   underrun       sticky: a sample slot opened without a valid sample
module dsm2_stim_echip65 #(
    parameter int DATA_WIDTH = 12,
    parameter int OSR        = 64,
    parameter int ACC_WIDTH  = DATA_WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    dsm2_stim_echip65_if.slave   smp,
    output logic                 bitstream_out,
    output logic                 frame_start,
    output logic                 overflow,
    output logic                 underrun
);
    localparam int CNT_W = (OSR > 2) ? $clog2(OSR) : 1;
    localparam int SUM_W = ACC_WIDTH + 2;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(OSR - 1);
    localparam logic signed [SUM_W-1:0] FS       = SUM_W'(1 << (DATA_WIDTH - 1));
    localparam logic signed [SUM_W-1:0] ACC_MAX  = SUM_W'((1 << (ACC_WIDTH - 1)) - 1);
    // Bitwise complement of the positive limit is exactly the negative limit.
    localparam logic signed [SUM_W-1:0] ACC_MIN  = ~ACC_MAX;

    logic [CNT_W-1:0]              cnt;
    logic signed [DATA_WIDTH-1:0]  x_hold;
    logic signed [ACC_WIDTH-1:0]   i1;
    logic signed [ACC_WIDTH-1:0]   i2;
    logic                          y;

    logic                          slot_open;
    logic                          accept;
    logic signed [DATA_WIDTH-1:0]  x_eff;
    logic signed [SUM_W-1:0]       fb;
    logic signed [SUM_W-1:0]       sum1;
    logic signed [SUM_W-1:0]       sum2;
    logic signed [ACC_WIDTH-1:0]   i1_next;
    logic signed [ACC_WIDTH-1:0]   i2_next;
    logic                          sat1;
    logic                          sat2;

    assign slot_open        = enable & (cnt == CNT_LAST);
    assign smp.sample_ready = slot_open & ~reset;
    assign accept           = smp.sample_ready & smp.sample_valid;
    assign bitstream_out    = y;

    always_comb begin
        // A sample accepted this cycle already drives the update at this edge,
        // so the new slot's first output bit appears together with frame_start.
        x_eff   = accept ? smp.sample_in : x_hold;
        fb      = y ? FS : -FS;

        sum1    = {{2{i1[ACC_WIDTH-1]}}, i1}
                + {{(SUM_W-DATA_WIDTH){x_eff[DATA_WIDTH-1]}}, x_eff}
                - fb;
        sat1    = 1'b0;
        i1_next = sum1[ACC_WIDTH-1:0];
        if (sum1 > ACC_MAX) begin
            i1_next = ACC_MAX[ACC_WIDTH-1:0];
            sat1    = 1'b1;
        end else if (sum1 < ACC_MIN) begin
            i1_next = ACC_MIN[ACC_WIDTH-1:0];
            sat1    = 1'b1;
        end

        // Second integrator consumes the freshly clamped first integrator.
        sum2    = {{2{i2[ACC_WIDTH-1]}}, i2}
                + {{2{i1_next[ACC_WIDTH-1]}}, i1_next}
                - fb;
        sat2    = 1'b0;
        i2_next = sum2[ACC_WIDTH-1:0];
        if (sum2 > ACC_MAX) begin
            i2_next = ACC_MAX[ACC_WIDTH-1:0];
            sat2    = 1'b1;
        end else if (sum2 < ACC_MIN) begin
            i2_next = ACC_MIN[ACC_WIDTH-1:0];
            sat2    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            x_hold      <= '0;
            i1          <= '0;
            i2          <= '0;
            y           <= 1'b0;
            frame_start <= 1'b0;
            overflow    <= 1'b0;
            underrun    <= 1'b0;
        end else if (enable) begin
            cnt         <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (accept) begin
                x_hold <= smp.sample_in;
            end
            i1          <= i1_next;
            i2          <= i2_next;
            y           <= ~i2_next[ACC_WIDTH-1];
            frame_start <= slot_open;
            if (sat1 | sat2) begin
                overflow <= 1'b1;
            end
            if (smp.sample_ready & ~smp.sample_valid) begin
                underrun <= 1'b1;
            end
        end else begin
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dsm2_stim_echip65.sv
// tb/tb_dsm2_stim_echip65.sv - self-checking bench for the delta-sigma stimulus modulator
module tb_dsm2_stim_echip65;
    localparam int OSR = 64;
    localparam int DW  = 12;
    localparam int FSV = 2048;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic bitstream_out, frame_start, overflow, underrun;

    always #5 clk = ~clk;

    dsm2_stim_echip65_if #(.DATA_WIDTH(DW)) sif ();

    dsm2_stim_echip65 #(.DATA_WIDTH(DW), .OSR(OSR)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .smp           (sif),
        .bitstream_out (bitstream_out),
        .frame_start   (frame_start),
        .overflow      (overflow),
        .underrun      (underrun)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural reference of the modulator equations, in plain integers.
    int m_cnt = 0, m_x = 0, m_i1 = 0, m_i2 = 0;
    bit m_y = 1'b0;
    int mm = 0;

    typedef struct {
        int sample;
        int settle;
        int window;
        int exp_ones;
        int tol;
        bit exp_ovf;
    } dc_vec_t;

    dc_vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Advance the reference with the inputs present before the edge, clock
    // the DUT, then compare the registered bit 1 ns after the edge.
    task automatic step();
        int vv;
        int a;
        int b;
        if (reset) begin
            m_cnt = 0; m_x = 0; m_i1 = 0; m_i2 = 0; m_y = 1'b0;
        end else if (enable) begin
            if (m_cnt == OSR - 1 && sif.sample_valid) m_x = int'(sif.sample_in);
            vv    = m_y ? FSV : -FSV;
            a     = clamp(m_i1 + m_x - vv);
            b     = clamp(m_i2 + a - vv);
            m_i1  = a;
            m_i2  = b;
            m_y   = (b >= 0);
            m_cnt = (m_cnt == OSR - 1) ? 0 : m_cnt + 1;
        end
        @(posedge clk);
        #1;
        if (bitstream_out !== m_y) mm++;
    endtask

    initial begin
        int zero_bits [8];
        int first_rdy;
        int ones;
        int fs_cnt;
        int fs_bad;
        int slot;
        int hold_bad;
        bit held;
        bit was_rdy;

        zero_bits = '{1, 1, 0, 1, 0, 0, 1, 1};
        vecs[0] = '{sample:    0, settle: 1024, window: 1024, exp_ones:  512, tol: 2, exp_ovf: 1'b0};
        vecs[1] = '{sample:  512, settle: 1024, window: 4096, exp_ones: 2560, tol: 4, exp_ovf: 1'b0};
        vecs[2] = '{sample: -512, settle: 1024, window: 4096, exp_ones: 1536, tol: 4, exp_ovf: 1'b0};
        vecs[3] = '{sample: 2047, settle:    0, window: 4096, exp_ones:   -1, tol: 0, exp_ovf: 1'b1};

        // Reset held with enable and valid high.
        reset = 1'b1;
        enable = 1'b1;
        sif.sample_valid = 1'b1;
        sif.sample_in = '0;
        for (int i = 0; i < 3; i++) step();
        check("reset_bit", int'(bitstream_out), 0);
        check("reset_ready", int'(sif.sample_ready), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_underrun", int'(underrun), 0);
        check("reset_frame_start", int'(frame_start), 0);

        // Zero input from reset: startup bits, first ready, frame cadence.
        reset = 1'b0;
        first_rdy = -1;
        ones = 0;
        fs_cnt = 0;
        fs_bad = 0;
        for (int k = 1; k <= 2048; k++) begin
            if (sif.sample_ready && first_rdy < 0) first_rdy = k - 1;
            step();
            if (k <= 8) check($sformatf("zero_bit%0d", k), int'(bitstream_out), zero_bits[k-1]);
            if (frame_start) begin
                fs_cnt++;
                if (k % OSR != 0) fs_bad++;
            end
            if (k > 1024) ones += int'(bitstream_out);
        end
        check("first_ready_cycles", first_rdy, OSR - 1);
        check_rng("zero_ones_1024", ones, 510, 514);
        check("frame_start_count", fs_cnt, 32);
        check("frame_start_offslot", fs_bad, 0);
        check("zero_overflow", int'(overflow), 0);
        check("zero_underrun", int'(underrun), 0);

        // DC vectors, each from a fresh reset.
        foreach (vecs[v]) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            sif.sample_in = DW'(vecs[v].sample);
            for (int i = 0; i < vecs[v].settle; i++) step();
            ones = 0;
            for (int i = 0; i < vecs[v].window; i++) begin
                step();
                ones += int'(bitstream_out);
            end
            if (vecs[v].exp_ones >= 0)
                check_rng($sformatf("dc_ones_%0d", vecs[v].sample), ones,
                          vecs[v].exp_ones - vecs[v].tol, vecs[v].exp_ones + vecs[v].tol);
            check($sformatf("dc_overflow_%0d", vecs[v].sample), int'(overflow), int'(vecs[v].exp_ovf));
        end

        // Overflow stays sticky after the input returns to zero; reset clears it.
        sif.sample_in = '0;
        for (int i = 0; i < 512; i++) step();
        check("overflow_sticky", int'(overflow), 1);
        reset = 1'b1;
        step();
        check("overflow_reset_clear", int'(overflow), 0);
        reset = 1'b0;

        // Handshake: one dropped slot, garbage between slots.
        mm = 0;
        slot = 0;
        sif.sample_in = DW'(700);
        for (int k = 0; k < OSR * 6; k++) begin
            was_rdy = sif.sample_ready;
            if (was_rdy) begin
                slot++;
                if (slot == 2) begin
                    check("underrun_before_drop", int'(underrun), 0);
                    sif.sample_in = DW'(-1500);
                    sif.sample_valid = 1'b0;
                end else begin
                    sif.sample_in = (slot == 1) ? DW'(700) : DW'(-300);
                    sif.sample_valid = 1'b1;
                end
            end else begin
                sif.sample_in = DW'($urandom_range(4095));
                sif.sample_valid = 1'($urandom_range(1));
            end
            step();
            if (was_rdy && slot == 2) check("underrun_at_drop", int'(underrun), 1);
        end
        check("handshake_model_bits", mm, 0);
        check("underrun_sticky", int'(underrun), 1);

        // Freeze mid-slot for 10 cycles, then resume.
        mm = 0;
        sif.sample_valid = 1'b1;
        sif.sample_in = DW'(512);
        for (int i = 0; i < 100; i++) step();
        enable = 1'b0;
        held = bitstream_out;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bitstream_out !== held || frame_start || sif.sample_ready) hold_bad++;
        end
        check("freeze_hold", hold_bad, 0);
        enable = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("freeze_resume_bits", mm, 0);

        // Reset in the middle of a later slot.
        while (m_cnt != 30) step();
        reset = 1'b1;
        step();
        check("midreset_bit", int'(bitstream_out), 0);
        check("midreset_underrun", int'(underrun), 0);
        check("midreset_frame_start", int'(frame_start), 0);
        check("midreset_ready", int'(sif.sample_ready), 0);
        reset = 1'b0;
        mm = 0;
        first_rdy = -1;
        for (int k = 1; k <= 200; k++) begin
            if (sif.sample_ready && first_rdy < 0) first_rdy = k - 1;
            step();
        end
        check("midreset_first_ready", first_rdy, OSR - 1);
        check("midreset_resume_bits", mm, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
